// File: rtl/shared_reg_arb_pkg.sv
// shared_reg_arb_pkg: shared types, defaults and index helper for the shared-register arbiter.
package shared_reg_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT = 2'd1, ST_COMMIT = 2'd2} state_e;
  localparam int DEF_CNT_W = 8;
  localparam logic [7:0] DEF_RST_VAL = 8'h00;
  function automatic int mod_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker starting the search just after last.
module rr_pick import shared_reg_arb_pkg::*; #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);
  always_comb begin
    logic [W-1:0] j;
    logic found;
    onehot = '0;
    idx = '0;
    found = 1'b0;
    j = last;
    for (int k = 0; k < N; k++) begin
      j = W'(mod_inc(int'(j), N));
      if (req[j] && !found) begin
        onehot[j] = 1'b1;
        idx = j;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: single-driver round-robin write controller for one shared register
// with a req/grant/ack handshake and a saturating contention counter.
module shared_reg_arbiter import shared_reg_arb_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(DEF_RST_VAL)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  input  logic                    clr_stat,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       reg_q,
  output logic                    busy,
  output logic [CNT_W-1:0]        contention_cnt
);
  localparam int W = $clog2(N_REQ);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] GRANT = ST_GRANT;
  localparam logic [1:0] COMMIT = ST_COMMIT;
  logic [1:0] state_q, state_d;
  logic [W-1:0] win_q, win_d, last_q, last_d, pick_idx;
  logic [N_REQ-1:0] pick_oh, win_oh;
  logic [DATA_W-1:0] data_q, data_d, lane;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rr_pick #(.N(N_REQ), .W(W)) u_pick (
    .req(req),
    .last(last_q),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  assign win_oh = N_REQ'(1) << win_q;
  assign lane = wdata[int'(win_q)*DATA_W +: DATA_W];
  // Abort, COMMIT and any illegal encoding all fall through to IDLE.
  always_comb begin
    state_d = IDLE;
    win_d = win_q;
    last_d = last_q;
    data_d = data_q;
    if (state_q == IDLE) begin
      state_d = |pick_oh ? GRANT : IDLE;
      win_d = |pick_oh ? pick_idx : win_q;
    end else if (state_q == GRANT && req[win_q]) begin
      state_d = COMMIT;
      data_d = lane;
      last_d = win_q;
    end
    cnt_d = clr_stat ? '0
          : (state_q == IDLE && $countones(req) >= 2 && cnt_q != '1) ? cnt_q + 1'b1
          : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q <= '0;
      last_q <= W'(N_REQ - 1);
      data_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      last_q <= last_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  assign grant = (state_q == GRANT) ? win_oh : '0;
  assign ack = (state_q == COMMIT) ? win_oh : '0;
  assign busy = state_q != IDLE;
  assign reg_q = data_q;
  assign contention_cnt = cnt_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: table-driven vectors plus hand sequences for saturation and async reset.
module tb_shared_reg_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_stat = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] wdata = '0;
  logic [3:0] grant, ack;
  logic [7:0] reg_q, cnt;
  logic busy;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic r, c;
    logic [3:0] rq;
    logic [31:0] wd;
    logic [3:0] g, a;
    logic [7:0] rv;
    logic b;
    logic [7:0] cn;
  } vec_t;
  vec_t tv[$];

  localparam logic [31:0] L1 = 32'h0000A500;
  localparam logic [31:0] RR = 32'h13121110;
  localparam logic [31:0] L2 = 32'h00770000;
  localparam logic [31:0] L02 = 32'h00330022;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(8), .RST_VAL(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .wdata(wdata),
    .clr_stat(clr_stat),
    .grant(grant),
    .ack(ack),
    .reg_q(reg_q),
    .busy(busy),
    .contention_cnt(cnt)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic [3:0] rq, input logic [31:0] wd,
                     input logic [3:0] g, input logic [3:0] a, input logic [7:0] rv,
                     input logic b, input logic [7:0] cn);
    vec_t v;
    v = '{r, c, rq, wd, g, a, rv, b, cn};
    tv.push_back(v);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_onehot0", 0, {31'b0, $onehot0(grant)}, 32'd1);
      chk("ack_grant_overlap", 0, {28'b0, grant & ack}, 32'd0);
    end
  end

  initial begin
    add(0, 0, 4'b0000, 0,   4'b0000, 4'b0000, 8'h00, 0, 0);
    add(0, 0, 4'b0010, L1,  4'b0010, 4'b0000, 8'h00, 1, 0);
    add(0, 0, 4'b0010, L1,  4'b0000, 4'b0010, 8'hA5, 1, 0);
    add(0, 0, 4'b0000, L1,  4'b0000, 4'b0000, 8'hA5, 0, 0);
    add(1, 0, 4'b0000, L1,  4'b0000, 4'b0000, 8'h00, 0, 0);
    add(0, 0, 4'b0000, RR,  4'b0000, 4'b0000, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      add(0, 0, 4'b1111, RR, 4'b0001 << (i % 4), 4'b0000,
          (i == 0) ? 8'h00 : 8'(8'h10 + (i - 1) % 4), 1, 8'(i + 1));
      add(0, 0, 4'b1111, RR, 4'b0000, 4'b0001 << (i % 4), 8'(8'h10 + i % 4), 1, 8'(i + 1));
      add(0, 0, 4'b1111, RR, 4'b0000, 4'b0000, 8'(8'h10 + i % 4), 0, 8'(i + 1));
    end
    add(0, 0, 4'b0100, L2,  4'b0100, 4'b0000, 8'h10, 1, 5);
    add(0, 0, 4'b0000, L2,  4'b0000, 4'b0000, 8'h10, 0, 5);
    add(0, 0, 4'b0101, L02, 4'b0100, 4'b0000, 8'h10, 1, 6);
    add(0, 0, 4'b0101, L02, 4'b0000, 4'b0100, 8'h33, 1, 6);
    add(0, 0, 4'b0011, L02, 4'b0000, 4'b0000, 8'h33, 0, 6);
    add(0, 0, 4'b0011, L02, 4'b0001, 4'b0000, 8'h33, 1, 7);
    add(0, 0, 4'b0011, L02, 4'b0000, 4'b0001, 8'h22, 1, 7);
    add(0, 1, 4'b0000, L02, 4'b0000, 4'b0000, 8'h22, 0, 0);
    add(0, 1, 4'b0011, L02, 4'b0010, 4'b0000, 8'h22, 1, 0);
    add(0, 0, 4'b0000, L02, 4'b0000, 4'b0000, 8'h22, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 0, grant, 0);
    chk("rst_ack", 0, ack, 0);
    chk("rst_busy", 0, busy, 0);
    chk("rst_reg", 0, reg_q, 0);
    chk("rst_cnt", 0, cnt, 0);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].r;
      clr_stat = tv[i].c;
      req = tv[i].rq;
      wdata = tv[i].wd;
      @(posedge clk);
      #1;
      chk("vec_grant", i, grant, tv[i].g);
      chk("vec_ack", i, ack, tv[i].a);
      chk("vec_reg", i, reg_q, tv[i].rv);
      chk("vec_busy", i, busy, tv[i].b);
      chk("vec_cnt", i, cnt, tv[i].cn);
    end

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      req = 4'b0011;
      @(negedge clk);
      req = 4'b0000;
    end
    @(posedge clk);
    #1;
    chk("sat_cnt", 0, cnt, 8'hFF);
    chk("sat_busy", 0, busy, 0);
    @(negedge clk);
    req = 4'b0011;
    clr_stat = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_cnt", 0, cnt, 0);
    chk("clr_grant", 0, grant, 4'b0010);
    @(negedge clk);
    req = 4'b0000;
    clr_stat = 1'b0;
    @(posedge clk);

    @(negedge clk);
    req = 4'b0001;
    wdata = 32'h0000005A;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_reg", 0, reg_q, 8'h5A);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    req = 4'b0001;
    wdata = 32'h00000099;
    @(posedge clk);
    #1;
    chk("pre_rst_grant", 0, grant, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("async_grant", 0, grant, 0);
    chk("async_ack", 0, ack, 0);
    chk("async_busy", 0, busy, 0);
    chk("async_reg", 0, reg_q, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b0000;
    @(posedge clk);
    #1;
    chk("post_rst_busy", 0, busy, 0);
    chk("post_rst_ack", 0, ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Single-driver write controller for one shared register that several requesters want to update.
- Replaces multi-driven assign/always structures: only this block drives the register.
- Round-robin arbitration with a req/grant/ack handshake, plus a saturating contention counter for lint/debug visibility.
- Sits between N client blocks and the shared state they all update.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, width of the shared register and of each write-data lane.
- CNT_W, 8, width of the contention counter.
- RST_VAL, 0, reset value of the shared register.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester write request; held until ack.
- wdata  input  N_REQ*DATA_W  lane i = bits [i*DATA_W +: DATA_W].
- grant  output  N_REQ  one-hot grant; all zero when idle.
- ack  output  N_REQ  one-cycle pulse to the requester whose write committed.
- reg_q  output  DATA_W  shared register value.
- busy  output  1  high whenever state != IDLE.
- contention_cnt  output  CNT_W  saturating count of contended arbitrations.
- clr_stat  input  1  synchronous clear of contention_cnt.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, grant=0, ack=0, busy=0.
  - reg_q=RST_VAL, contention_cnt=0.
  - RR pointer last=N_REQ-1, so requester 0 has priority first.
- FSM states: IDLE, GRANT, COMMIT.
- IDLE:
  - If req!=0 at edge k, select the winner w = first set bit searching last+1, last+2, … modulo N_REQ.
  - Register w and go to GRANT.
  - If req==0, stay in IDLE.
- GRANT (cycle k+1):
  - grant[w]=1.
  - If req[w]=1 at edge k+2: capture reg_q <= wdata lane w, last <= w, go to COMMIT.
  - If req[w]=0 at edge k+2 (abort): no write, last unchanged, go to IDLE, no ack.
- COMMIT (cycle k+2):
  - grant=0, ack[w]=1 for exactly this cycle; reg_q already holds the new value.
  - Go to IDLE at edge k+3.
- Latency and throughput:
  - Request seen at edge k gives ack in cycle k+2.
  - Maximum rate is one committed write per 3 cycles.
- Requester rules:
  - wdata lane must be stable while grant is high.
  - Requester drops req in the cycle after ack. If req is still high in IDLE, it is a new request.
- Contention counter:
  - In IDLE, at any edge where popcount(req)>=2, increment contention_cnt.
  - Saturates at all-ones; no wrap.
  - clr_stat has priority over the increment on the same edge.
- Selection logic:
  - Fully specified and fully parallel, with an explicit default on every branch.
  - No casex/casez wildcards, so no lint full/parallel warnings.
  - No latches; each output is driven from exactly one process.
- Reset mid-operation: from any state, rst returns everything to reset values immediately. A pending ack is lost and reg_q reverts to RST_VAL.
- Illegal or unreachable state encoding: recover to IDLE with grant=0 and ack=0.

Decomposition:
- Shared package (shared_reg_arb_pkg):
  - State enum (IDLE, GRANT, COMMIT).
  - Default-value constants for RST_VAL and CNT_W.
  - A function for the modulo-N index increment.
- Sub-module rr_pick: a combinational round-robin one-hot picker with inputs req and last, and outputs onehot and idx. It is natural to isolate because it is reused by other arbiters and is lint-checked standalone.

Test Plan:
- Reset checks:
  - Assert rst mid-GRANT, with reg_q=0x5A before the write → grant=0, ack=0, busy=0, reg_q=RST_VAL (0x00) asynchronously, before the next clk edge.
- Single requester:
  - req=4'b0010, lane1=0xA5 at edge 0 → grant=4'b0010 in cycle 1, ack=4'b0010 and reg_q=0xA5 in cycle 2, busy=0 in cycle 3.
- Round-robin fairness:
  - Hold req=4'b1111 with lane i = 0x10+i → ack order 0,1,2,3,0, with one ack every 3 cycles.
  - reg_q sequence 0x10,0x11,0x12,0x13,0x10.
- Abort:
  - req=4'b0100, drop req[2] during GRANT → no ack, reg_q unchanged, busy=0 next cycle.
  - Next request from 0 and 2 together grants 2 first, because the pointer did not advance.
- Contention counter:
  - Present 2 simultaneous requesters for 300 IDLE decisions with CNT_W=8 → contention_cnt saturates at 255.
  - clr_stat together with a contended edge → 0.
- Simultaneous events:
  - req rises on a new requester during COMMIT → not sampled until IDLE; exactly one grant bit is ever high; ack never overlaps grant.
